// File: rtl/serial_load_driver.sv
// rtl/serial_load_driver.sv - framed serial deserialiser driving a register's d/load port
// Optional even-parity bit between data and stop: define SERIAL_LOAD_PARITY_EN.
module serial_load_driver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_en,
  output logic [WIDTH-1:0] d,
  output logic             load,
  output logic             frame_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] d_n;
  logic             load_n, frame_err_n, busy_n;
`ifdef SERIAL_LOAD_PARITY_EN
  logic             par_bad, par_bad_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      d         <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_LOAD_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      d         <= d_n;
      load      <= load_n;
      frame_err <= frame_err_n;
      busy      <= busy_n;
`ifdef SERIAL_LOAD_PARITY_EN
      par_bad   <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    shreg_n     = shreg;
    d_n         = d;
    load_n      = 1'b0;
    frame_err_n = 1'b0;
`ifdef SERIAL_LOAD_PARITY_EN
    par_bad_n   = par_bad;
`endif
    if (ser_en) begin
      case (state)
        IDLE: begin
          if (!ser_in) begin
            state_n = DATA;
            cnt_n   = '0;
          end
        end
        DATA: begin
          for (int i = 0; i < WIDTH; i++) begin
            if (cnt == i[CNT_W-1:0]) shreg_n[i] = ser_in;
          end
          cnt_n = cnt + 1'b1;
          if (cnt == LAST) begin
`ifdef SERIAL_LOAD_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
`ifdef SERIAL_LOAD_PARITY_EN
        PARITY: begin
          par_bad_n = ^{shreg, ser_in};
          state_n   = STOP;
        end
`endif
        STOP: begin
          state_n = IDLE;
`ifdef SERIAL_LOAD_PARITY_EN
          if (ser_in && !par_bad) begin
`else
          if (ser_in) begin
`endif
            d_n    = shreg;
            load_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    // busy mirrors the registered state, so it tracks the edge that enters/leaves IDLE
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_serial_load_driver.sv
// tb/tb_serial_load_driver.sv - table-driven and randomized check of serial_load_driver
module tb_serial_load_driver;

`ifdef SERIAL_LOAD_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ser_in = 1'b1;
  logic       ser_en = 1'b0;
  logic [3:0] d;
  logic       load, frame_err, busy;

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] d_model = 4'b0;

  serial_load_driver #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .ser_in(ser_in), .ser_en(ser_en),
    .d(d), .load(load), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       stop;
    logic       flip;
    int         stride;
    logic       exp_load;
    logic [3:0] exp_d;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic in, input logic en);
    @(negedge clk);
    ser_in = in;
    ser_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] data, input logic stop, input logic flip,
                            input int stride, input logic exp_load, input logic [3:0] exp_d);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 4; i++) bits.push_back(data[i]);
    if (PAR) bits.push_back(^data ^ flip);
    bits.push_back(stop);
    for (int b = 0; b < bits.size(); b++) begin
      for (int g = 1; g < stride; g++) begin
        cyc(1'($urandom_range(0, 1)), 1'b0);
        chk("gap_busy", busy, (b != 0));
        chk("gap_load", load, 0);
        chk("gap_d", d, d_model);
      end
      cyc(bits[b], 1'b1);
      if (b == bits.size() - 1) begin
        chk("busy_end", busy, 0);
        chk("load", load, exp_load);
        chk("frame_err", frame_err, !exp_load);
        chk("d", d, exp_d);
      end else begin
        chk("busy", busy, 1);
        chk("load_mid", load, 0);
        chk("err_mid", frame_err, 0);
      end
    end
    if (exp_load) d_model = exp_d;
  endtask

  initial begin
    tbl[0] = '{4'b1010, 1'b1, 1'b0, 1, 1'b1, 4'b1010};
    tbl[1] = '{4'b1100, 1'b0, 1'b0, 1, 1'b0, 4'b1010};
    tbl[2] = '{4'b1100, 1'b1, 1'b0, 3, 1'b1, 4'b1100};
    tbl[3] = '{4'b0000, 1'b1, 1'b0, 1, 1'b1, 4'b0000};
    tbl[4] = '{4'b1111, 1'b1, 1'b0, 2, 1'b1, 4'b1111};
    tbl[5] = '{4'b1010, 1'b1, 1'b1, 1, !PAR, PAR ? 4'b1111 : 4'b1010};
    tbl[6] = '{4'b0101, 1'b1, 1'b0, 1, 1'b1, 4'b0101};

    // reset held for three cycles with the line idle
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0);
      chk("rst_d", d, 0);
      chk("rst_load", load, 0);
      chk("rst_err", frame_err, 0);
      chk("rst_busy", busy, 0);
    end
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i])
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].flip, tbl[i].stride,
                 tbl[i].exp_load, tbl[i].exp_d);

    // reset after two data bits discards the frame and clears d
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("mid_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    ser_in = 1'b0;
    ser_en = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_d", d, 0);
    chk("mr_load", load, 0);
    chk("mr_err", frame_err, 0);
    chk("mr_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    ser_in = 1'b1;
    d_model = 4'b0;
    send_frame(4'b0110, 1'b1, 1'b0, 1, 1'b1, 4'b0110);

    // randomized frames against the frame-level reference model
    for (int n = 0; n < 40; n++) begin
      logic [3:0] data;
      logic       stop, flip, good;
      int         idle;
      data = 4'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      flip = ($urandom_range(0, 3) == 0);
      good = stop && !(PAR && flip);
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        cyc(1'b1, 1'b1);
        chk("idle_busy", busy, 0);
        chk("idle_d", d, d_model);
      end
      send_frame(data, stop, flip, $urandom_range(1, 3), good, good ? data : d_model);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
